fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, the number of requesters (2..8).
REQ-002 The block SHALL have parameter DSIZE, default 8, the data word width in bits.
REQ-003 The block SHALL have parameter BURST, default 4, the maximum words per grant (1..16).
REQ-004 The block SHALL have port clk  input  1  the single clock (FIFO write clock); rising edge active.
REQ-005 The block SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 The block SHALL have port in_valid  input  NREQ  per-requester word valid.
REQ-007 The block SHALL have port in_data  input  NREQ*DSIZE  per-requester word; requester i occupies bits [i*DSIZE +: DSIZE].
REQ-008 The block SHALL have port in_ready  output  NREQ  per-requester word accepted this cycle when valid is also high.
REQ-009 The block SHALL have port fifo_wfull  input  1  FIFO write-side full flag.
REQ-010 The block SHALL have port fifo_winc  output  1  FIFO write increment.
REQ-011 The block SHALL have port fifo_wdata  output  DSIZE  FIFO write data.
REQ-012 The block SHALL have port busy  output  1  high while a grant is held.
REQ-013 The block SHALL have port gnt_id  output  $clog2(NREQ)  index of the current or last granted requester.
REQ-014 The block SHALL have port stall_cnt  output  16  granted-but-full cycle count (see Configuration).

Function
REQ-015 The FSM SHALL have two states, IDLE and GRANT.
REQ-016 In IDLE with any in_valid high, the block SHALL select the first valid requester at or after rr_ptr (modulo NREQ), register it into gnt_id, and enter GRANT on the next edge (1-cycle arbitration latency).
REQ-017 In IDLE with no in_valid high, the block SHALL remain in IDLE, and gnt_id and rr_ptr SHALL hold.
REQ-018 in_ready[i] SHALL be combinationally (state==GRANT && gnt_id==i && !fifo_wfull); all other bits SHALL be 0.
REQ-019 fifo_winc SHALL equal in_valid[gnt_id] && in_ready[gnt_id]; fifo_wdata SHALL equal in_data of gnt_id, with zero latency.
REQ-020 A beat counter (0..BURST-1) SHALL increment on each fifo_winc in GRANT and SHALL clear on leaving GRANT.
REQ-021 GRANT SHALL release to IDLE when a transfer occurs with beat counter == BURST-1.
REQ-022 GRANT SHALL release to IDLE on any cycle in which in_valid[gnt_id] is low (requester drop).
REQ-023 On release, rr_ptr SHALL become (gnt_id+1) mod NREQ, wrapping from NREQ-1 to 0.
REQ-024 While fifo_wfull is high in GRANT, the grant SHALL be held, no write SHALL occur, and the beat counter SHALL hold.
REQ-025 When fifo_wfull and in_valid[gnt_id] drop in the same cycle, the drop rule SHALL apply.
REQ-026 busy SHALL be 1 exactly when state==GRANT.
REQ-027 Valid changes of non-granted requesters SHALL NOT affect the current grant.

Reset
REQ-028 While rst_n is low: state=IDLE, rr_ptr=0, gnt_id=0, beat counter=0, stall_cnt=0, busy=0.
REQ-029 While rst_n is low, in_ready and fifo_winc SHALL be 0.
REQ-030 Reset asserted mid-burst SHALL abort the burst immediately with no further write.

Configuration
REQ-031 With macro FIFO_ARB_STALL_CNT_EN defined, stall_cnt SHALL increment on each GRANT cycle with fifo_wfull high and in_valid[gnt_id] high, saturating at 16'hFFFF.
REQ-032 Without FIFO_ARB_STALL_CNT_EN, stall_cnt SHALL be constant 0 and no counter logic SHALL be synthesised.

Verification
REQ-033 Single requester: in_valid[2] held high, words 0x10..0x15, fifo_wfull=0 -> grant after 1 cycle, 4 writes 0x10..0x13, 1 IDLE cycle, re-grant to 2, then writes 0x14,0x15.
REQ-034 Round-robin: all 4 valid continuously -> grant order 0,1,2,3,0 with 4 writes each; rr_ptr wraps 3->0.
REQ-035 Backpressure: fifo_wfull high for 3 cycles mid-burst -> fifo_winc=0 and in_ready=0 for those cycles, burst completes 4 words, stall_cnt=3 with macro and 0 without.
REQ-036 Drop: requester 1 deasserts valid after 2 words -> release, rr_ptr=2, next grant to requester 2 if valid.
REQ-037 Reset mid-burst after 1 word -> outputs return to reset values asynchronously; after release the first grant goes to the lowest valid index from 0.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter that funnels NREQ valid/ready word
// streams into the write port of a single FIFO. A grant is held for up to
// BURST words, or until the granted requester drops its valid, and is then
// handed to the next requester after it in round-robin order.
//
// Optional feature: define FIFO_ARB_STALL_CNT_EN to build a saturating
// counter of cycles where the granted requester was blocked by a full FIFO.
// Without the macro stall_cnt is tied to zero and no counter exists.
module fifo_wr_arbiter #(
  parameter int NREQ  = 4,
  parameter int DSIZE = 8,
  parameter int BURST = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           in_valid,
  input  logic [NREQ*DSIZE-1:0]     in_data,
  output logic [NREQ-1:0]           in_ready,
  input  logic                      fifo_wfull,
  output logic                      fifo_winc,
  output logic [DSIZE-1:0]          fifo_wdata,
  output logic                      busy,
  output logic [$clog2(NREQ)-1:0]   gnt_id,
  output logic [15:0]               stall_cnt
);

  localparam int IW = $clog2(NREQ);
  localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t          state;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   sel_id;
  logic [IW-1:0]   next_ptr;
  logic [BW-1:0]   beat;
  logic            gnt_valid;
  logic            last_beat;

  // Pick the first valid requester at or after rr_ptr, wrapping modulo NREQ.
  // Scanning from the farthest offset back to offset 0 lets the closest
  // valid requester overwrite the others without an early loop exit.
  // NOTE: every signal written in an always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    sel_id = rr_ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      int idx;
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (in_valid[idx]) sel_id = IW'(idx);
    end
  end

  assign gnt_valid = in_valid[gnt_id];
  assign last_beat = (beat == BW'(BURST - 1));
  assign next_ptr  = (gnt_id == IW'(NREQ - 1)) ? '0 : gnt_id + IW'(1);
  assign busy      = (state == GRANT);
  assign fifo_winc = (state == GRANT) && gnt_valid && !fifo_wfull;

  // Ready goes only to the granted requester, and only while the FIFO has room.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      in_ready[i] = (state == GRANT) && (gnt_id == IW'(i)) && !fifo_wfull;
    end
  end

  // Route the granted requester's word straight to the FIFO write data.
  always_comb begin
    fifo_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_id == IW'(i)) fifo_wdata = in_data[i*DSIZE +: DSIZE];
    end
  end

  // Arbitration FSM: grant selection, beat counting and release handling.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rr_ptr <= '0;
      gnt_id <= '0;
      beat   <= '0;
    end else begin
      case (state)
        IDLE: begin
          beat <= '0;
          if (|in_valid) begin
            gnt_id <= sel_id;
            state  <= GRANT;
          end
        end
        GRANT: begin
          if (!gnt_valid) begin
            // Requester dropped: release even if the FIFO is also full.
            state  <= IDLE;
            beat   <= '0;
            rr_ptr <= next_ptr;
          end else if (fifo_winc) begin
            if (last_beat) begin
              state  <= IDLE;
              beat   <= '0;
              rr_ptr <= next_ptr;
            end else begin
              beat <= beat + BW'(1);
            end
          end
          // Full FIFO with valid held: keep grant and beat count as they are.
        end
        default: begin
          state <= IDLE;
          beat  <= '0;
        end
      endcase
    end
  end

`ifdef FIFO_ARB_STALL_CNT_EN
  // Count granted cycles blocked by a full FIFO, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if ((state == GRANT) && fifo_wfull && gnt_valid &&
                 (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter (NREQ=4, DSIZE=8, BURST=4). Each requester
// is a word queue driven with valid/ready; the expected FIFO write sequence
// is queued when stimulus is loaded and a monitor checks every write.
module tb_fifo_wr_arbiter;

  localparam int NREQ  = 4;
  localparam int DSIZE = 8;
  localparam int BURST = 4;

  typedef struct {
    int id;
    int data;
  } exp_t;

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       in_valid;
  logic [NREQ*DSIZE-1:0] in_data;
  logic [NREQ-1:0]       in_ready;
  logic                  fifo_wfull;
  logic                  fifo_winc;
  logic [DSIZE-1:0]      fifo_wdata;
  logic                  busy;
  logic [1:0]            gnt_id;
  logic [15:0]           stall_cnt;

  int total = 0;
  int bad   = 0;

  logic [7:0] src_q[NREQ][$];
  exp_t       exp_q[$];

  fifo_wr_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .BURST(BURST)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .fifo_wfull (fifo_wfull),
    .fifo_winc  (fifo_winc),
    .fifo_wdata (fifo_wdata),
    .busy       (busy),
    .gnt_id     (gnt_id),
    .stall_cnt  (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic load(input int id, input int data);
    exp_t e;
    src_q[id].push_back(8'(data));
    e.id   = id;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(input int budget);
    bit done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk);
      done = (src_q[0].size() == 0) && (src_q[1].size() == 0) &&
             (src_q[2].size() == 0) && (src_q[3].size() == 0) &&
             !busy && (exp_q.size() == 0);
    end
    check("drain", 32'(done), 32'd1);
  endtask

  // Requester model: sample handshakes mid-cycle, retire accepted words just
  // after the edge, then present the next word of each queue.
  initial begin
    logic [NREQ-1:0] acc;
    in_valid = '0;
    in_data  = '0;
    forever begin
      @(negedge clk);
      acc = in_valid & in_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        in_valid[i] = (src_q[i].size() > 0);
        in_data[i*DSIZE +: DSIZE] = (src_q[i].size() > 0) ? src_q[i][0] : 8'h00;
      end
    end
  end

  // Monitor: every FIFO write must match the head of the expected queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && fifo_winc) begin
        check("write_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("wdata", 32'(fifo_wdata), 32'(e.data));
          check("gnt_id", 32'(gnt_id), 32'(e.id));
          check("in_ready", 32'(in_ready), 32'(1 << e.id));
        end
      end
    end
  end

  initial begin
    int exp_busy[10] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 0};
    int exp_stall;

    rst_n      = 1'b0;
    fifo_wfull = 1'b0;
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_gnt_id", 32'(gnt_id), 32'd0);
    check("rst_stall", 32'(stall_cnt), 32'd0);
    check("rst_winc", 32'(fifo_winc), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single requester 2: burst of 4, one idle cycle, re-grant, then drop.
    @(negedge clk);
    for (int k = 0; k < 6; k++) load(2, 8'h10 + k);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("s1_busy_%0d", k), 32'(busy), 32'(exp_busy[k]));
      if (k == 8) begin
        check("s1_drop_winc", 32'(fifo_winc), 32'd0);
        check("s1_drop_gnt", 32'(gnt_id), 32'd2);
      end
    end
    wait_drain(50);

    // Round robin: all four valid, grant order 0,1,2,3,0,1,2,3.
    apply_reset();
    @(negedge clk);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NREQ; i++)
        for (int k = 0; k < BURST; k++)
          load(i, i * 16 + r * 4 + k);
    wait_drain(200);

    // Backpressure: FIFO full for 3 cycles after two words of a burst.
    apply_reset();
    @(negedge clk);
    for (int k = 0; k < 4; k++) load(0, 8'hA0 + k);
    repeat (4) @(posedge clk);
    #1 fifo_wfull = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("s3_winc_%0d", k), 32'(fifo_winc), 32'd0);
      check($sformatf("s3_ready_%0d", k), 32'(in_ready), 32'd0);
      check($sformatf("s3_busy_%0d", k), 32'(busy), 32'd1);
    end
    @(posedge clk);
    #1 fifo_wfull = 1'b0;
    wait_drain(50);
`ifdef FIFO_ARB_STALL_CNT_EN
    exp_stall = 3;
`else
    exp_stall = 0;
`endif
    check("s3_stall_cnt", 32'(stall_cnt), 32'(exp_stall));

    // Drop: requester 1 leaves after 2 words; rr_ptr=2 so requester 2 wins
    // over requester 0, which became valid mid-grant without disturbing it.
    apply_reset();
    @(negedge clk);
    load(1, 8'h31);
    load(1, 8'h32);
    src_q[2].push_back(8'h41);
    src_q[2].push_back(8'h42);
    @(negedge clk);
    @(negedge clk);
    src_q[0].push_back(8'h51);
    src_q[0].push_back(8'h52);
    begin
      exp_t e;
      e.id = 2; e.data = 'h41; exp_q.push_back(e);
      e.id = 2; e.data = 'h42; exp_q.push_back(e);
      e.id = 0; e.data = 'h51; exp_q.push_back(e);
      e.id = 0; e.data = 'h52; exp_q.push_back(e);
    end
    wait_drain(60);

    // Reset mid-burst after one word of requester 3.
    apply_reset();
    @(negedge clk);
    load(3, 8'hC0);
    src_q[3].push_back(8'hC1);
    src_q[3].push_back(8'hC2);
    src_q[3].push_back(8'hC3);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("s5_busy", 32'(busy), 32'd0);
    check("s5_winc", 32'(fifo_winc), 32'd0);
    check("s5_ready", 32'(in_ready), 32'd0);
    check("s5_gnt_id", 32'(gnt_id), 32'd0);
    check("s5_stall", 32'(stall_cnt), 32'd0);
    load(1, 8'hD0);
    load(1, 8'hD1);
    load(2, 8'hE0);
    begin
      exp_t e;
      e.id = 3; e.data = 'hC1; exp_q.push_back(e);
      e.id = 3; e.data = 'hC2; exp_q.push_back(e);
      e.id = 3; e.data = 'hC3; exp_q.push_back(e);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_drain(80);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "time limit");
  end

endmodule
